// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Each grant latches a payload, issues one memory command, and routes the response to its owner.
module mem_port_arbiter #(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter bit          LS_PRIORITY = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DW-1:0]     if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [DW/8-1:0]   ls_be,
    input  logic [AW-1:0]     ls_addr,
    input  logic [DW-1:0]     ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DW-1:0]     ls_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DW/8-1:0]   mem_be,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DW-1:0]     mem_rdata
);

    localparam int unsigned BW = DW / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_e;

    state_e state_q, state_d;
    logic   owner_ls_q;
    logic   last_ls_q;
    logic   pick_ls;
    logic   grant;

    // LS wins when alone, when it has priority, or when IF was served last
    always_comb begin
        state_d   = state_q;
        grant     = 1'b0;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        pick_ls   = ls_req && (!if_req || LS_PRIORITY || !last_ls_q);
        case (state_q)
            ST_IDLE: begin
                if (reset && (if_req || ls_req)) begin
                    grant   = 1'b1;
                    if_gnt  = !pick_ls;
                    ls_gnt  = pick_ls;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    if_rvalid = reset && !owner_ls_q;
                    ls_rvalid = reset && owner_ls_q;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign if_rdata = mem_rdata;
    assign ls_rdata = mem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command payload is captured on grant and held until the next grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_ls_q <= 1'b0;
            last_ls_q  <= 1'b1;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else if (grant) begin
            owner_ls_q <= pick_ls;
            last_ls_q  <= pick_ls;
            mem_req    <= 1'b1;
            mem_we     <= pick_ls && ls_we;
            mem_be     <= pick_ls ? ls_be : {BW{1'b1}};
            mem_addr   <= pick_ls ? ls_addr : if_addr;
            mem_wdata  <= pick_ls ? ls_wdata : '0;
        end else if (state_q == ST_REQ && mem_gnt) begin
            mem_req    <= 1'b0;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between instruction fetch (IF) and load/store (LS). Each request is accepted with a one-cycle grant and its payload is latched. The arbiter then drives one memory transaction at a time and routes the response back to the requester that owns it. It sits between the pipeline's fetch and memory stages and the external memory/bus interface.

## Interface
- AW, 32, address width
- DW, 32, data width; byte-enable width is DW/8
- LS_PRIORITY, 0, 0 = round-robin between IF and LS; 1 = LS always wins a tie
- clk  in  1  clock, all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; address held until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DW  fetch data
- ls_req  in  1  load/store request; payload held until ls_gnt
- ls_we  in  1  1 = store
- ls_be  in  DW/8  byte enables
- ls_addr  in  AW  load/store address
- ls_wdata  in  DW  store data
- ls_gnt  out  1  LS request accepted this cycle
- ls_rvalid  out  1  load data valid / store acknowledge
- ls_rdata  out  DW  load data
- mem_req, mem_we, mem_be, mem_addr, mem_wdata  out  1/1/DW/8/AW/DW  registered memory command
- mem_gnt  in  1  memory accepted the command
- mem_rvalid  in  1  memory response, one per accepted command; for writes as well
- mem_rdata  in  DW  memory read data

## Operation
- FSM with states IDLE, REQ and WAIT, plus an owner register (IF/LS) and a last-served register.
- IDLE:
  - If any req is high, pick a winner and assert its gnt combinationally in the same cycle.
  - Latch the winner's payload into the mem_* registers and set owner. Next state is REQ.
  - For IF: mem_we=0 and mem_be=all ones.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting, LS_PRIORITY=1: LS wins.
  - Both requesting, LS_PRIORITY=0: the requester not recorded in last-served wins. Last-served updates on every grant.
- REQ: mem_req=1 with the latched payload. The payload does not change while waiting. On mem_gnt, clear mem_req and go to WAIT.
- WAIT:
  - On mem_rvalid, assert the owner's rvalid in the same cycle (combinational pass-through) and go to IDLE.
  - The non-owner's rvalid stays 0.
- if_rdata and ls_rdata both equal mem_rdata. They are meaningful only while the corresponding rvalid is high.
- mem_rvalid in IDLE or REQ is ignored and not routed. This covers stray responses and responses left over from before a reset.
- if_gnt and ls_gnt are never high in the same cycle. Neither is ever high outside IDLE.
- A requester whose req drops before gnt is simply not served. No state is kept for it.

## Timing
- Reset (reset=0), effective immediately and asynchronously:
  - State goes to IDLE and owner to IF.
  - last-served goes to LS, so IF wins the first tie.
  - All mem_* outputs go to 0.
  - if_gnt, ls_gnt, if_rvalid and ls_rvalid are 0 while reset is low.
- Reset in REQ or WAIT abandons the transaction. No rvalid is produced for it.
- Minimum latency, with mem_gnt in the first REQ cycle and mem_rvalid one cycle later:
  - Cycle 0: req and gnt.
  - Cycle 1: mem_req and mem_gnt.
  - Cycle 2: mem_rvalid and the owner's rvalid.
  - Cycle 3: IDLE, next grant possible.
- Peak throughput is one transaction per 3 cycles.
- mem_req may be held for any number of cycles waiting for mem_gnt. WAIT may last any number of cycles.
- A req that is high during REQ or WAIT is granted in the first IDLE cycle after.

## Test plan
- Reset then a single fetch.
  - Stimulus: reset low for 2 cycles; if_addr=0x100 with if_req; memory grants immediately and returns 0xDEADBEEF one cycle later.
  - Response: if_gnt at cycle 0; mem_addr=0x100, mem_we=0, mem_be=0xF at cycle 1; if_rvalid with if_rdata=0xDEADBEEF at cycle 2; ls_rvalid never high.
- Store.
  - Stimulus: ls_we=1, ls_be=0x3, ls_addr=0x2000, ls_wdata=0x1234.
  - Response: mem_* carries exactly these values; ls_rvalid is pulsed once on the write acknowledge.
- Round-robin.
  - Stimulus: LS_PRIORITY=0; both reqs held high continuously.
  - Response: grants alternate IF, LS, IF, LS; gnts are never concurrent.
- Priority.
  - Stimulus: LS_PRIORITY=1; both reqs held high.
  - Response: LS is granted every time; IF is granted only after ls_req drops.
- Stall and stray response.
  - Stimulus: mem_gnt withheld for 5 cycles; a spurious mem_rvalid pulse during REQ.
  - Response: mem_req and payload are stable for all 5 cycles; the spurious pulse produces no rvalid; exactly one rvalid after the real response.
- Reset mid-transaction.
  - Stimulus: reset asserted in WAIT; mem_rvalid arrives after reset is released.
  - Response: outputs are 0 immediately; no rvalid is produced; the next request is served normally.
